// File: rtl/pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_fifo
// Brief    : Elastic in-order pipeline stage buffer with valid/ready on both
//            sides, synchronous flush, input-side stall and an optional
//            registered-ready mode that cuts the ready combinational path.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 2,
    parameter bit REG_READY = 1'b0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_stall,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [DATA_W-1:0]          i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DATA_W-1:0]          o_out_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    // Storage is deliberately left out of reset; only occupancy is tracked.
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q,  count_d;

    logic w_push;
    logic w_pop;

    // Pointer increment that wraps at DEPTH-1, valid for any DEPTH.
    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    assign o_empty     = (count_q == '0);
    assign o_full      = (count_q == c_cnt_full);
    assign o_count     = count_q;
    assign o_out_valid = !o_empty && !i_flush;
    assign o_out_data  = mem_q[rd_ptr_q];

    assign w_pop  = o_out_valid && i_out_ready;
    assign w_push = i_in_valid && o_in_ready;

    generate
        if (REG_READY) begin : g_ready_reg
            // Ready from registered occupancy only: no path from i_out_ready.
            assign o_in_ready = !o_full && !i_stall && !i_flush;
        end else begin : g_ready_comb
            // A pop in the same cycle frees the slot, allowing full throughput.
            assign o_in_ready = (!o_full || w_pop) && !i_stall && !i_flush;
        end
    endgenerate

    // Next-state for pointers and occupancy; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload write; push already excludes flush and stall.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_in_data;
        end
    end

    // Protocol sanity checks.
    a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_push && o_full && !w_pop));
    a_no_underflow : assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_pop && o_empty));
    a_count_range : assert property (@(posedge i_clk) disable iff (i_rst)
        count_q <= c_cnt_full);

endmodule
`default_nettype wire

// File: doc/pipe_stage_fifo.md
Name: pipe_stage_fifo

Overview:
- Parametrised elastic pipeline stage that replaces single-entry stage registers between CPU pipeline stages, e.g. fetch→decode and decode→execute.
- Buffers up to DEPTH packets in order with a valid/ready handshake on both sides.
- Supports a synchronous flush, an input-side stall, and a selectable registered-ready mode that breaks the combinational ready path.
- Payload is an opaque DATA_W-bit vector; the instantiating stage packs and unpacks its packet struct.

Parameters:
DATA_W, 32, payload width in bits (>=1).
DEPTH, 2, number of entries (>=1; need not be a power of two).
REG_READY, 0, 0 = o_in_ready may depend combinationally on i_out_ready; 1 = o_in_ready depends on registered state, i_stall and i_flush only.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_flush  in  1  synchronous flush: discard all entries.
i_stall  in  1  block input acceptance; output side unaffected.
i_in_valid  in  1  upstream packet valid.
o_in_ready  out  1  stage accepts a packet this cycle.
i_in_data  in  DATA_W  upstream payload.
o_out_valid  out  1  head entry valid.
i_out_ready  in  1  downstream accepts the head entry.
o_out_data  out  DATA_W  head entry payload.
o_count  out  $clog2(DEPTH+1)  current occupancy.
o_empty  out  1  o_count == 0.
o_full  out  1  o_count == DEPTH.

Behaviour:
- Reset (async assert, released synchronously to i_clk):
  - count = 0, read and write pointers = 0.
  - o_out_valid = 0, o_empty = 1, o_full = 0.
  - Storage contents are not reset.
- Definitions:
  - push = i_in_valid && o_in_ready.
  - pop = o_out_valid && i_out_ready.
- Output side:
  - o_out_valid = !o_empty && !i_flush.
  - o_out_data = entry at the read pointer. Don't-care when o_out_valid = 0; the bench must not check it then.
- Input side:
  - REG_READY=0: o_in_ready = (!o_full || pop) && !i_stall && !i_flush.
  - REG_READY=1: o_in_ready = !o_full && !i_stall && !i_flush.
- Latency and ordering:
  - A pushed packet is visible on the output the cycle after the push, with no same-cycle bypass, including when the buffer is empty.
  - Strict FIFO order is maintained.
- Clock-edge update:
  - push only: write at the write pointer, advance it, count +1.
  - pop only: advance the read pointer, count −1.
  - push and pop together: both pointers advance, count unchanged. This is legal at any occupancy, including full (REG_READY=0 only) and count == 1.
  - Pointers wrap from DEPTH−1 to 0; DEPTH that is not a power of two must wrap correctly.
- Flush:
  - i_flush has priority over everything. At the edge, count = 0 and both pointers = 0.
  - During the flush cycle, o_in_ready = 0 and o_out_valid = 0, so no handshake completes.
- Stall:
  - i_stall = 1 forces o_in_ready = 0 only. Pops continue and the buffer may drain.
- Protocol rules:
  - Once o_out_valid rises, the head data holds stable until it is popped or flushed.
  - Upstream may drop i_in_valid without a handshake; the stage imposes no requirement on upstream.
- DEPTH=1, REG_READY=0: behaves as a single-register stage with pass-through ready, giving full throughput.
- DEPTH=1, REG_READY=1: throughput is limited to one packet every 2 cycles.
- Mid-operation reset: asynchronous reset clears state immediately and drops o_out_valid in the same cycle.
- Assertions:
  - Error if push occurs while full without a pop.
  - Error if pop occurs while empty.
  - Error if o_count > DEPTH.

Test Plan:
- Streaming: DEPTH=2, REG_READY=0, i_in_data 0x1..0x8 pushed back-to-back, i_out_ready=1 → outputs 0x1..0x8 in order, one per cycle, first one cycle after the first push; o_count stays 1.
- Backpressure fill/drain: DEPTH=3, i_out_ready=0, push 0xA,0xB,0xC,0xD → o_full after 3 pushes, o_in_ready=0, 0xD held upstream; then i_out_ready=1 → 0xA,0xB,0xC,0xD out in order.
- Full-with-pop:
  - REG_READY=0, DEPTH=2, full, i_out_ready=1 and i_in_valid=1 in the same cycle → push accepted, count stays 2.
  - Same stimulus with REG_READY=1 → o_in_ready=0, count drops to 1.
- Flush mid-stream: DEPTH=4 holding 3 entries, assert i_flush with i_in_valid=1 for one cycle → no handshake that cycle; next cycle o_count=0, o_out_valid=0. A subsequent push of 0x55 emerges as the first output.
- Stall: 2 entries held, i_stall=1 for 3 cycles with i_in_valid=1 and i_out_ready=1 → no pushes, both entries drain, o_empty=1; stall released → input resumes.
- Wrap and reset:
  - DEPTH=3, 10 push/pop cycles with random ready → ordering preserved across pointer wrap.
  - Async i_rst pulsed mid-cycle with 2 entries held → o_out_valid=0 immediately, o_count=0.
